// File: rtl/cpu_branch_pkg.sv
// Shared types and helpers for the branch/CON/PC unit: FSM state encoding,
// default datapath widths and the offset sign-extension helper.
package cpu_branch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_COND = 2'd1,
    APPLY     = 2'd2,
    DONE      = 2'd3
  } br_state_e;

  localparam int DATA_W_DEF   = 32;
  localparam int OFFSET_W_DEF = 19;
  localparam int SEXT_MAX_W   = 64;

  // Replicates bit (width-1) of raw into every bit at or above width.
  function automatic logic [SEXT_MAX_W-1:0] sign_extend(input logic [SEXT_MAX_W-1:0] raw,
                                                        input int width);
    logic [SEXT_MAX_W-1:0] result;
    logic                  sign_bit;
    sign_bit = 1'b0;
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i == width - 1) sign_bit = raw[i];
    end
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      result[i] = (i < width) ? raw[i] : sign_bit;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_con_pc_unit_con_ff.sv
// Architectural CON flip-flop: captures the condition decoder result whenever
// con_in is strobed, cleared asynchronously by clear_n.
module con_ff (
  input  logic clock,
  input  logic clear_n,
  input  logic con_in,
  input  logic d_in,
  output logic con_out
);

  logic con_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      con_q <= 1'b0;
    end else if (con_in) begin
      con_q <= d_in;
    end
  end

  assign con_out = con_q;

endmodule

// File: rtl/branch_con_pc_unit.sv
// CON flip-flop, PC register and conditional-branch sequencer.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module branch_con_pc_unit
  import cpu_branch_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                OFFSET_W = OFFSET_W_DEF,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              pc_in,
  input  logic              inc_pc,
  input  logic              con_in,
  input  logic              d_in,
  input  logic              br_start,
  input  logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] pc_out,
  output logic              con_out,
  output logic              br_busy,
  output logic              br_done,
  output logic              br_taken,
  output logic              br_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       not_taken_cnt
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  br_state_e         state_q;
  logic [DATA_W-1:0] off_q;
  logic [DATA_W-1:0] off_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  logic [7:0]        cnt_q;
  logic              done_q;
  logic              taken_q;
  logic              err_q;
  logic              apply_taken;
  logic              unused_ir_bits;

  con_ff u_con_ff (
    .clock   (clock),
    .clear_n (clear_n),
    .con_in  (con_in),
    .d_in    (d_in),
    .con_out (con_out)
  );

  assign off_d          = DATA_W'(sign_extend(SEXT_MAX_W'(ir[OFFSET_W-1:0]), OFFSET_W));
  assign unused_ir_bits = ^ir[DATA_W-1:OFFSET_W];

  // APPLY reads the CON value latched on the edge that left WAIT_COND.
  assign apply_taken = (state_q == APPLY) && con_out;

  always_comb begin
    pc_d = pc_q;
    if (pc_in) begin
      pc_d = bus_data;
    end else if (apply_taken) begin
      pc_d = pc_q + off_q;
    end else if (inc_pc) begin
      pc_d = pc_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (br_start) begin
            off_q   <= off_d;
            cnt_q   <= '0;
            state_q <= WAIT_COND;
          end
        end
        WAIT_COND: begin
          if (con_in) begin
            state_q <= APPLY;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        APPLY: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          taken_q <= con_out;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pc_out   = pc_q;
  assign br_busy  = (state_q != IDLE);
  assign br_done  = done_q;
  assign br_taken = taken_q;
  assign br_err   = err_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] not_taken_cnt_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else if (done_q) begin
      if (taken_q) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else if (!err_q) begin
        if (not_taken_cnt_q != 16'hFFFF) not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_con_pc_unit.sv
// Self-checking bench for branch_con_pc_unit: directed branch scenarios plus
// randomized branches scored against a plain-arithmetic reference model.
module tb_branch_con_pc_unit;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [31:0] bus_data;
  logic        pc_in;
  logic        inc_pc;
  logic        con_in;
  logic        d_in;
  logic        br_start;
  logic [31:0] ir;
  logic [31:0] pc_out;
  logic        con_out;
  logic        br_busy;
  logic        br_done;
  logic        br_taken;
  logic        br_err;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;
`endif

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] modelPc;
  logic        modelCon;

  branch_con_pc_unit #(
    .DATA_W   (32),
    .OFFSET_W (19),
    .TIMEOUT  (TIMEOUT),
    .RESET_PC (32'h0)
  ) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .bus_data (bus_data),
    .pc_in    (pc_in),
    .inc_pc   (inc_pc),
    .con_in   (con_in),
    .d_in     (d_in),
    .br_start (br_start),
    .ir       (ir),
    .pc_out   (pc_out),
    .con_out  (con_out),
    .br_busy  (br_busy),
    .br_done  (br_done),
    .br_taken (br_taken),
    .br_err   (br_err)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setPc(input logic [31:0] v);
    bus_data = v;
    pc_in    = 1'b1;
    tick();
    pc_in    = 1'b0;
    modelPc  = v;
  endtask

  // Branch target: PC plus the signed 19-bit offset field, mod 2^32.
  function automatic logic [31:0] branchTarget(input logic [31:0] pc, input logic [31:0] irVal);
    longint off;
    off = longint'(irVal & 32'h0007FFFF);
    if (off >= 262144) off = off - 524288;
    return 32'(longint'(pc) + off);
  endfunction

  // Reference outcome of one branch given when CON arrives (cycles after br_start).
  task automatic expectBranch(input logic [31:0] pc, input logic [31:0] irVal, input int conDelay,
                              input logic dVal, input logic pcInApply, input logic incApply,
                              input logic [31:0] busVal, input logic conBefore,
                              output int expDone, output logic expTaken, output logic expErr,
                              output logic [31:0] expPc, output logic expCon);
    if (conDelay >= 1 && conDelay <= TIMEOUT) begin
      expDone  = conDelay + 2;
      expTaken = dVal;
      expErr   = 1'b0;
      expCon   = dVal;
      if (pcInApply)     expPc = busVal;
      else if (dVal)     expPc = branchTarget(pc, irVal);
      else if (incApply) expPc = pc + 32'd1;
      else               expPc = pc;
    end else begin
      expDone  = TIMEOUT + 1;
      expTaken = 1'b0;
      expErr   = 1'b1;
      expCon   = conBefore;
      expPc    = pc;
    end
  endtask

  // Drives one branch and reports what the DUT showed on its br_done cycle.
  task automatic doBranch(input logic [31:0] irVal, input int conDelay, input logic dVal,
                          input logic pcInApply, input logic incApply, input logic [31:0] busVal,
                          input logic spam, output int doneCycle, output logic taken,
                          output logic err, output logic [31:0] pcAfter, output logic conAfter,
                          output logic busyAt1, output logic idleAfter);
    int c;
    doneCycle = -1;
    taken     = 1'b0;
    err       = 1'b0;
    pcAfter   = '0;
    conAfter  = 1'b0;
    ir        = irVal;
    br_start  = 1'b1;
    tick();
    br_start  = 1'b0;
    ir        = $urandom;
    busyAt1   = br_busy;
    c         = 1;
    while (c < 40 && doneCycle < 0) begin
      con_in   = (c == conDelay);
      d_in     = (c == conDelay) ? dVal : logic'($urandom_range(0, 1));
      pc_in    = pcInApply && (c == conDelay + 1);
      inc_pc   = incApply && (c == conDelay + 1);
      bus_data = busVal;
      br_start = spam && (c == 2);
      tick();
      c++;
      con_in   = 1'b0;
      pc_in    = 1'b0;
      inc_pc   = 1'b0;
      br_start = 1'b0;
      if (br_done) begin
        doneCycle = c;
        taken     = br_taken;
        err       = br_err;
        pcAfter   = pc_out;
        conAfter  = con_out;
      end
    end
    br_start  = spam;
    tick();
    br_start  = 1'b0;
    idleAfter = !br_busy && !br_done;
  endtask

  task automatic test_reset();
    logic sawDone;
    testsRun++;
    if (pc_out !== 32'h0 || con_out !== 1'b0 || br_busy !== 1'b0 || br_done !== 1'b0 ||
        br_taken !== 1'b0 || br_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: pc=%h con=%b busy=%b done=%b taken=%b err=%b, required all zero",
               pc_out, con_out, br_busy, br_done, br_taken, br_err);
    end
    con_in = 1'b1;
    d_in   = 1'b1;
    tick();
    con_in = 1'b0;
    setPc(32'h40);
    ir       = 32'h5;
    br_start = 1'b1;
    tick();
    br_start = 1'b0;
    tick();
    #2 clear_n = 1'b0;
    #1;
    testsRun++;
    if (pc_out !== 32'h0 || con_out !== 1'b0 || br_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_branch: pc=%h con=%b busy=%b, required pc=0 con=0 busy=0",
               pc_out, con_out, br_busy);
    end
    @(negedge clock);
    clear_n  = 1'b1;
    modelPc  = 32'h0;
    modelCon = 1'b0;
    sawDone  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (br_done || br_busy) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0 || pc_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_done: activity=%b pc=%h, required activity=0 pc=0", sawDone, pc_out);
    end
  endtask

  task automatic test_taken_forward();
    int dc; logic tk, er, cn, b1, ia; logic [31:0] pa;
    setPc(32'h10);
    doBranch(32'h00005, 1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, dc, tk, er, pa, cn, b1, ia);
    testsRun++;
    if (dc !== 3 || tk !== 1'b1 || er !== 1'b0 || pa !== 32'h15 || b1 !== 1'b1 || ia !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL taken_forward: done@%0d taken=%b err=%b pc=%h busy1=%b idle=%b, required done@3 taken=1 err=0 pc=00000015 busy1=1 idle=1",
               dc, tk, er, pa, b1, ia);
    end
    modelPc = pc_out;
    modelCon = con_out;
  endtask

  task automatic test_taken_backward();
    int dc; logic tk, er, cn, b1, ia; logic [31:0] pa;
    setPc(32'h00000002);
    doBranch(32'h7FFFC, 1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, dc, tk, er, pa, cn, b1, ia);
    testsRun++;
    if (dc !== 3 || tk !== 1'b1 || pa !== 32'hFFFFFFFE) begin
      testsFailed++;
      $display("[TB] FAIL taken_backward_wrap: done@%0d taken=%b pc=%h, required done@3 taken=1 pc=fffffffe",
               dc, tk, pa);
    end
    modelPc = pc_out;
  endtask

  task automatic test_not_taken();
    int dc; logic tk, er, cn, b1, ia; logic [31:0] pa;
    setPc(32'h20);
    doBranch(32'h00010, 1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, dc, tk, er, pa, cn, b1, ia);
    testsRun++;
    if (dc !== 3 || tk !== 1'b0 || er !== 1'b0 || pa !== 32'h20 || cn !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL not_taken: done@%0d taken=%b err=%b pc=%h con=%b, required done@3 taken=0 err=0 pc=00000020 con=0",
               dc, tk, er, pa, cn);
    end
    modelPc = pc_out;
    modelCon = con_out;
  endtask

  task automatic test_timeout();
    int dc; logic tk, er, cn, b1, ia; logic [31:0] pa;
    setPc(32'h55);
    doBranch(32'h00003, 99, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, dc, tk, er, pa, cn, b1, ia);
    testsRun++;
    if (dc !== TIMEOUT + 1 || er !== 1'b1 || tk !== 1'b0 || pa !== 32'h55) begin
      testsFailed++;
      $display("[TB] FAIL timeout: done@%0d err=%b taken=%b pc=%h, required done@%0d err=1 taken=0 pc=00000055",
               dc, er, tk, pa, TIMEOUT + 1);
    end
    testsRun++;
    if (ia !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL start_in_done_ignored: idle=%b, required 1", ia);
    end
    modelPc = pc_out;
  endtask

  task automatic test_priority();
    int dc; logic tk, er, cn, b1, ia; logic [31:0] pa;
    setPc(32'h20);
    doBranch(32'h00010, 1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, dc, tk, er, pa, cn, b1, ia);
    testsRun++;
    if (tk !== 1'b1 || pa !== 32'h100) begin
      testsFailed++;
      $display("[TB] FAIL priority_pcin: taken=%b pc=%h, required taken=1 pc=00000100", tk, pa);
    end
    setPc(32'h20);
    doBranch(32'h00010, 1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, dc, tk, er, pa, cn, b1, ia);
    testsRun++;
    if (tk !== 1'b1 || pa !== 32'h30) begin
      testsFailed++;
      $display("[TB] FAIL priority_inc: taken=%b pc=%h, required taken=1 pc=00000030", tk, pa);
    end
    modelPc = pc_out;
    modelCon = con_out;
  endtask

  task automatic test_idle_pc_con();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      v        = $urandom;
      pc_in    = logic'($urandom_range(0, 1));
      inc_pc   = logic'($urandom_range(0, 1));
      con_in   = logic'($urandom_range(0, 1));
      d_in     = logic'($urandom_range(0, 1));
      bus_data = v;
      if (pc_in)       modelPc = v;
      else if (inc_pc) modelPc = modelPc + 32'd1;
      if (con_in)      modelCon = d_in;
      tick();
      pc_in = 1'b0; inc_pc = 1'b0; con_in = 1'b0;
      testsRun++;
      if (pc_out !== modelPc || con_out !== modelCon) begin
        testsFailed++;
        $display("[TB] FAIL idle_pc_con[%0d]: pc=%h con=%b, required pc=%h con=%b",
                 i, pc_out, con_out, modelPc, modelCon);
      end
    end
  endtask

  task automatic test_random_branches();
    int dc, expDone, conDelay; logic tk, er, cn, b1, ia, dVal, pIn, inc, expTaken, expErr, expCon;
    logic [31:0] pa, irVal, busVal, expPc, startPc;
    for (int i = 0; i < 24; i++) begin
      startPc  = $urandom;
      setPc(startPc);
      irVal    = $urandom;
      conDelay = $urandom_range(1, TIMEOUT + 2);
      dVal     = logic'($urandom_range(0, 1));
      pIn      = ($urandom_range(0, 3) == 0);
      inc      = logic'($urandom_range(0, 1));
      busVal   = $urandom;
      expectBranch(startPc, irVal, conDelay, dVal, pIn, inc, busVal, modelCon,
                   expDone, expTaken, expErr, expPc, expCon);
      doBranch(irVal, conDelay, dVal, pIn, inc, busVal, logic'($urandom_range(0, 1)),
               dc, tk, er, pa, cn, b1, ia);
      testsRun++;
      if (dc !== expDone || tk !== expTaken || er !== expErr || pa !== expPc || cn !== expCon ||
          ia !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL random_branch[%0d]: done@%0d taken=%b err=%b pc=%h con=%b idle=%b, required done@%0d taken=%b err=%b pc=%h con=%b idle=1",
                 i, dc, tk, er, pa, cn, ia, expDone, expTaken, expErr, expPc, expCon);
      end
      modelCon = expCon;
      modelPc  = pc_out;
    end
  endtask

  initial begin
    clear_n  = 1'b0;
    bus_data = '0;
    pc_in    = 1'b0;
    inc_pc   = 1'b0;
    con_in   = 1'b0;
    d_in     = 1'b0;
    br_start = 1'b0;
    ir       = '0;
    modelPc  = '0;
    modelCon = 1'b0;
    #12;
    test_reset();
    test_taken_forward();
    test_taken_backward();
    test_not_taken();
    test_timeout();
    test_priority();
    test_idle_pc_con();
    test_random_branches();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
